// File: rtl/alu_sel_pkg.sv
// Shared constants and FSM state type for the ALU result-mux select controller.
package alu_sel_pkg;
  localparam int NUM_CHANNELS = 16;
  localparam int OP_W         = 4;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/alu_select_controller_if.sv
// Opcode handshake, multiplexer select/data and result handshake of the select controller.
// master = controller side, slave = opcode source / multiplexer / result sink.
interface alu_select_controller_if #(
  parameter int BUS_SIZE = 16
);
  import alu_sel_pkg::*;

  logic                    op_valid;
  logic [OP_W-1:0]         op_code;
  logic                    op_ready;
  logic [NUM_CHANNELS-1:0] sel;
  logic [BUS_SIZE-1:0]     mux_b;
  logic                    res_valid;
  logic [BUS_SIZE-1:0]     res_data;
  logic                    res_err;
  logic                    res_ready;

  modport master (
    input  op_valid, op_code, mux_b, res_ready,
    output op_ready, sel, res_valid, res_data, res_err
  );

  modport slave (
    output op_valid, op_code, mux_b, res_ready,
    input  op_ready, sel, res_valid, res_data, res_err
  );
endinterface

// File: rtl/alu_sel_decode.sv
// Combinational 4-to-16 one-hot decoder with enable; all-zero when disabled.
module alu_sel_decode
  import alu_sel_pkg::*;
(
  input  logic                    en,
  input  logic [OP_W-1:0]         idx,
  output logic [NUM_CHANNELS-1:0] onehot
);

  // One-hot expansion of the channel index
  always_comb begin
    onehot = {NUM_CHANNELS{1'b0}};
    if (en) begin
      onehot = NUM_CHANNELS'(1) << idx;
    end else begin
      onehot = {NUM_CHANNELS{1'b0}};
    end
  end

endmodule

// File: rtl/alu_select_controller.sv
// Sequences one-hot mux select, settle window, result capture and result handshake.
// Optional macro ALU_SEL_OPMASK_EN rejects opcodes whose OP_MASK bit is clear.
module alu_select_controller
  import alu_sel_pkg::*;
#(
  parameter int                      BUS_SIZE      = 16,
  parameter int                      SETTLE_CYCLES = 1,
  parameter logic [NUM_CHANNELS-1:0] OP_MASK       = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_select_controller_if.master bus
);

  state_e                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [NUM_CHANNELS-1:0] sel_r, dec_s;
  logic [BUS_SIZE-1:0]     res_data_r;
  logic                    res_valid_r, res_err_r;
  logic                    op_ok_s, op_ready_s, accept_s, capture_s, consume_s;

`ifdef ALU_SEL_OPMASK_EN
  assign op_ok_s = OP_MASK[bus.op_code];
`else
  logic unused_mask;
  assign unused_mask = ^OP_MASK;
  assign op_ok_s     = 1'b1;
`endif

  alu_sel_decode u_decode (
    .en     (accept_s && op_ok_s),
    .idx    (bus.op_code),
    .onehot (dec_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic; a masked opcode skips the settle window entirely
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.op_valid)           state_s = op_ok_s ? DRIVE : HOLD;
               else                        state_s = IDLE;
      DRIVE:   if (cnt_r == {CNT_W{1'b0}}) state_s = HOLD;
               else                        state_s = DRIVE;
      HOLD:    if (bus.res_ready)          state_s = IDLE;
               else                        state_s = HOLD;
      default:                             state_s = IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    op_ready_s = 1'b0;
    capture_s  = 1'b0;
    consume_s  = 1'b0;
    case (state_r)
      IDLE:    op_ready_s = 1'b1;
      DRIVE:   capture_s  = (cnt_r == {CNT_W{1'b0}});
      HOLD:    consume_s  = bus.res_ready;
      default: op_ready_s = 1'b0;
    endcase
    accept_s = op_ready_s && bus.op_valid;
  end

  // Select, settle counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r       <= {NUM_CHANNELS{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      res_data_r  <= {BUS_SIZE{1'b0}};
      res_valid_r <= 1'b0;
      res_err_r   <= 1'b0;
    end else if (accept_s && op_ok_s) begin
      sel_r <= dec_s;
      cnt_r <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (accept_s) begin
      res_data_r  <= {BUS_SIZE{1'b0}};
      res_err_r   <= 1'b1;
      res_valid_r <= 1'b1;
    end else if (capture_s) begin
      sel_r       <= {NUM_CHANNELS{1'b0}};
      res_data_r  <= bus.mux_b;
      res_err_r   <= 1'b0;
      res_valid_r <= 1'b1;
    end else if (state_r == DRIVE) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else if (consume_s) begin
      res_valid_r <= 1'b0;
    end
  end

  assign bus.op_ready  = op_ready_s;
  assign bus.sel       = sel_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_err   = res_err_r;

endmodule

// File: tb/tb_alu_select_controller.sv
// Randomized + directed bench for alu_select_controller against a timeline reference model.
module tb_alu_select_controller;
  localparam int S3 = 3;
`ifdef ALU_SEL_OPMASK_EN
  localparam logic [15:0] MASK = 16'hFFFE;
`else
  localparam logic [15:0] MASK = 16'hFFFF;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_select_controller_if #(.BUS_SIZE(16)) bus1 ();
  alu_select_controller_if #(.BUS_SIZE(16)) bus3 ();

  alu_select_controller #(.BUS_SIZE(16), .SETTLE_CYCLES(1), .OP_MASK(MASK)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1));
  alu_select_controller #(.BUS_SIZE(16), .SETTLE_CYCLES(S3), .OP_MASK(MASK)) dut3 (
    .clk (clk), .rst_n (rst_n), .bus (bus3));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Timeline model: an accepted op at edge t0 drives sel until t0+S3, where mux_b is captured
  int          cyc = 0;
  int          t0 = 0;
  bit          active = 0;
  bit          pend = 0;
  logic [3:0]  code = 4'd0;
  logic [15:0] exp_data = 16'h0000;
  logic        exp_err = 1'b0;

  task automatic model_reset();
    active = 0; pend = 0; exp_data = 16'h0000; exp_err = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] c, input logic [15:0] b, input logic r);
    logic [15:0] m;
    bit ok;
    m = MASK;
`ifdef ALU_SEL_OPMASK_EN
    ok = m[c];
`else
    ok = 1;
`endif
    if (pend) begin
      if (r) pend = 0;
    end else if (active) begin
      if (cyc == t0 + S3) begin
        exp_data = b; exp_err = 1'b0; pend = 1; active = 0;
      end
    end else if (v) begin
      if (ok) begin
        active = 1; t0 = cyc; code = c;
      end else begin
        pend = 1; exp_data = 16'h0000; exp_err = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    logic [15:0] esel;
    esel = active ? (16'h0001 << code) : 16'h0000;
    check_eq("sel",       {16'h0, bus3.sel},       {16'h0, esel});
    check_eq("op_ready",  {31'h0, bus3.op_ready},  {31'h0, ~(active | pend)});
    check_eq("res_valid", {31'h0, bus3.res_valid}, {31'h0, pend});
    check_eq("res_data",  {16'h0, bus3.res_data},  {16'h0, exp_data});
    check_eq("res_err",   {31'h0, bus3.res_err},   {31'h0, exp_err});
  endtask

  // Starts and ends on a falling edge
  task automatic step(input logic v, input logic [3:0] c, input logic [15:0] b, input logic r);
    bus3.op_valid = v; bus3.op_code = c; bus3.mux_b = b; bus3.res_ready = r;
    @(posedge clk);
    model_edge(v, c, b, r);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    bus1.op_valid = 1'b0; bus1.op_code = 4'd0; bus1.mux_b = 16'h0; bus1.res_ready = 1'b0;
    bus3.op_valid = 1'b0; bus3.op_code = 4'd0; bus3.mux_b = 16'h0; bus3.res_ready = 1'b0;

    #12;
    check_eq("rst_sel",   {16'h0, bus3.sel},       32'h0);
    check_eq("rst_valid", {31'h0, bus3.res_valid}, 32'h0);
    check_eq("rst_data",  {16'h0, bus3.res_data},  32'h0);
    check_eq("rst_err",   {31'h0, bus3.res_err},   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_op_ready", {31'h0, bus3.op_ready}, 32'h1);
    @(negedge clk);

    // SETTLE_CYCLES=1 instance: op 15, one sel cycle, result one cycle after accept
    bus1.op_valid = 1'b1; bus1.op_code = 4'd15; bus1.mux_b = 16'h0080;
    @(negedge clk);
    check_eq("s1_sel",       {16'h0, bus1.sel},       32'h0000_8000);
    check_eq("s1_valid_pre", {31'h0, bus1.res_valid}, 32'h0);
    bus1.op_valid = 1'b0;
    @(negedge clk);
    check_eq("s1_sel_off", {16'h0, bus1.sel},       32'h0);
    check_eq("s1_valid",   {31'h0, bus1.res_valid}, 32'h1);
    check_eq("s1_data",    {16'h0, bus1.res_data},  32'h0000_0080);
    bus1.res_ready = 1'b1;
    @(negedge clk);
    check_eq("s1_consumed", {31'h0, bus1.res_valid}, 32'h0);
    check_eq("s1_ready",    {31'h0, bus1.op_ready},  32'h1);
    bus1.res_ready = 1'b0;

    check_outputs();

    // Settle window: mux_b correct only on the third select cycle
    step(1'b1, 4'd0, 16'h1111, 1'b0);
    step(1'b0, 4'd0, 16'hDEAD, 1'b0);
    step(1'b0, 4'd0, 16'hDEAD, 1'b0);
    step(1'b0, 4'd0, 16'h0002, 1'b0);
    check_eq("settle_data", {16'h0, bus3.res_data}, 32'h0000_0002);
    step(1'b0, 4'd0, 16'h0000, 1'b1);

    // Backpressure with a competing opcode offered
    step(1'b1, 4'd7, 16'h0000, 1'b0);
    step(1'b0, 4'd0, 16'h0000, 1'b0);
    step(1'b0, 4'd0, 16'h0000, 1'b0);
    step(1'b0, 4'd0, 16'h00A5, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'd2, 16'h5A5A, 1'b0);
    check_eq("bp_data", {16'h0, bus3.res_data}, 32'h0000_00A5);
    step(1'b1, 4'd2, 16'h5A5A, 1'b1);
    step(1'b1, 4'd2, 16'h5A5A, 1'b0);
    check_eq("bp_accept_sel", {16'h0, bus3.sel}, 32'h0000_0004);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 16'h0000, 1'b1);

    // Reset in the middle of the settle window
    step(1'b1, 4'd5, 16'h0000, 1'b0);
    step(1'b0, 4'd0, 16'h0000, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_sel",   {16'h0, bus3.sel},       32'h0);
    check_eq("mid_rst_valid", {31'h0, bus3.res_valid}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 16'hFFFF, 1'b1);

`ifdef ALU_SEL_OPMASK_EN
    step(1'b1, 4'd0, 16'h1234, 1'b0);
    check_eq("mask_sel",   {16'h0, bus3.sel},       32'h0);
    check_eq("mask_valid", {31'h0, bus3.res_valid}, 32'h1);
    check_eq("mask_err",   {31'h0, bus3.res_err},   32'h1);
    check_eq("mask_data",  {16'h0, bus3.res_data},  32'h0);
    step(1'b0, 4'd0, 16'h0000, 1'b1);
`endif

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
